// File: rtl/clks_alot_p.sv
`default_nettype none
// ============================================================================
// clks_alot_p: shared clock-state types for the clks_alot generator/recovery
// Revision: 1.0
// ============================================================================
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH           = 16;
    localparam int RECOVERY_SYNC_STAGES_DEFAULT = 2;

    typedef struct packed {
        logic rising;
        logic falling;
        logic high_quarter;
        logic low_quarter;
    } clock_events_s;

    typedef struct packed {
        logic                          locked;
        logic                          pause_active;
        logic [RATE_COUNTER_WIDTH-1:0] pause_duration;
    } clock_status_s;

    typedef struct packed {
        logic          clk;
        clock_events_s events;
        clock_status_s status;
    } clock_states_s;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRST   = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } recovery_state_e;

    function automatic logic [RATE_COUNTER_WIDTH-1:0] abs_diff(
        input logic [RATE_COUNTER_WIDTH-1:0] a,
        input logic [RATE_COUNTER_WIDTH-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_recovery_if.sv
`default_nettype none
// ============================================================================
// clock_recovery_if: recovered clock-state bundle and locked half period
// Revision: 1.0
// ============================================================================
interface clock_recovery_if;
    import clks_alot_p::*;

    clock_states_s                 recovered_state_o;
    logic [RATE_COUNTER_WIDTH-1:0] half_rate_o;

    modport master (
        output recovered_state_o,
        output half_rate_o
    );

    modport slave (
        input recovered_state_o,
        input half_rate_o
    );
endinterface
`default_nettype wire

// File: rtl/clock_recovery_io_sync.sv
`default_nettype none
// ============================================================================
// io_sync: N-stage flop synchronizer for a single asynchronous level
// Revision: 1.0
// ============================================================================
module io_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_recovery.sv
`default_nettype none
// ============================================================================
// clock_recovery: measures an async io clock's half period and locks onto it
// Revision: 1.0
// ============================================================================
module clock_recovery
    import clks_alot_p::*;
#(
    parameter int SYNC_STAGES = RECOVERY_SYNC_STAGES_DEFAULT,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             enable_i,
    input  logic             clear_state_i,
    input  logic             io_clk_i,
    clock_recovery_if.master rec_if
);

    localparam int               W           = RATE_COUNTER_WIDTH;
    localparam int               MATCH_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]     PHASE_MAX   = '1;
    localparam logic [W-1:0]     TOL         = W'(TOLERANCE);
    localparam logic [W+1:0]     TOL_WIDE    = (W+2)'(TOLERANCE);
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

    logic sync_lvl;

    io_sync #(
        .STAGES (SYNC_STAGES)
    ) u_io_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (io_clk_i),
        .sync_o  (sync_lvl)
    );

    recovery_state_e    state_q;
    logic               prev_q;
    logic [W-1:0]       phase_q;
    logic [W-1:0]       ref_q;
    logic [MATCH_W-1:0] match_q;
    clock_events_s      events_q;
    logic               locked_q;
    logic [W-1:0]       half_rate_q;

    logic               io_edge;
    logic               force_idle;
    logic [W-1:0]       phase_next;
    logic [W-1:0]       sample;
    logic               in_tol;
    logic               timeout;
    logic [W-1:0]       ref_half;
    logic               quarter_hit;
    logic [MATCH_W-1:0] match_inc;

    always_comb begin
        io_edge     = (sync_lvl != prev_q);
        force_idle  = clear_state_i || !enable_i;
        sample      = (phase_q == PHASE_MAX) ? PHASE_MAX : (phase_q + 1'b1);
        phase_next  = io_edge ? '0 : sample;
        in_tol      = (abs_diff(sample, ref_q) <= TOL);
        // Allowance is a full period plus tolerance before declaring the clock stopped
        timeout     = ({2'b00, phase_q} > (({2'b00, ref_q} << 1) + TOL_WIDE)) ||
                      (phase_q == PHASE_MAX);
        ref_half    = ref_q >> 1;
        quarter_hit = (ref_half != '0) && (phase_next == ref_half);
        match_inc   = match_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= 1'b0;
            phase_q     <= '0;
            ref_q       <= '0;
            match_q     <= '0;
            events_q    <= '0;
            locked_q    <= 1'b0;
            half_rate_q <= '0;
        end else if (clk_en) begin
            prev_q   <= sync_lvl;
            phase_q  <= phase_next;
            events_q <= '0;
            if (force_idle) begin
                state_q     <= IDLE;
                phase_q     <= '0;
                ref_q       <= '0;
                match_q     <= '0;
                locked_q    <= 1'b0;
                half_rate_q <= '0;
            end else begin
                if (state_q != IDLE) begin
                    events_q.rising  <= io_edge && sync_lvl;
                    events_q.falling <= io_edge && !sync_lvl;
                end
                unique case (state_q)
                    IDLE: begin
                        state_q <= FIRST;
                    end
                    FIRST: begin
                        // The first observed edge ends a partial period; discard it
                        if (io_edge) begin
                            state_q <= ACQUIRE;
                            ref_q   <= '0;
                            match_q <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (io_edge) begin
                            if (in_tol) begin
                                match_q <= match_inc;
                                if (match_inc == LOCK_TARGET) begin
                                    state_q     <= LOCKED;
                                    locked_q    <= 1'b1;
                                    half_rate_q <= ref_q;
                                end
                            end else begin
                                ref_q   <= sample;
                                match_q <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (io_edge) begin
                            if (!in_tol) begin
                                state_q     <= ACQUIRE;
                                ref_q       <= sample;
                                match_q     <= '0;
                                locked_q    <= 1'b0;
                                half_rate_q <= '0;
                            end
                        end else if (timeout) begin
                            state_q     <= FIRST;
                            locked_q    <= 1'b0;
                            half_rate_q <= '0;
                        end else if (quarter_hit) begin
                            events_q.high_quarter <= prev_q;
                            events_q.low_quarter  <= !prev_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rec_if.recovered_state_o               = '0;
        rec_if.recovered_state_o.clk           = prev_q;
        rec_if.recovered_state_o.events        = events_q;
        rec_if.recovered_state_o.status.locked = locked_q;
        rec_if.half_rate_o                     = half_rate_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_recovery.sv
`default_nettype none
// ============================================================================
// tb_clock_recovery: directed scoreboard bench for clock_recovery
// Revision: 1.0
// ============================================================================
module tb_clock_recovery;
    import clks_alot_p::*;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_HQ   = 2;
    localparam int K_LQ   = 3;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk           = 1'b0;
    logic rst_n         = 1'b0;
    logic clk_en        = 1'b1;
    logic enable_i      = 1'b0;
    logic clear_state_i = 1'b0;
    logic io_clk_i      = 1'b0;

    bit   en_toggle  = 1'b0;
    bit   en_at_edge = 1'b1;
    int   cyc        = 0;
    int   n_cmp      = 0;
    int   n_err      = 0;
    exp_t sb[$];

    clock_recovery_if rec_if ();

    clock_recovery #(
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4),
        .TOLERANCE   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .enable_i      (enable_i),
        .clear_state_i (clear_state_i),
        .io_clk_i      (io_clk_i),
        .rec_if        (rec_if)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc        = cyc + 1;
            en_at_edge = clk_en;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            clk_en = en_toggle ? ~clk_en : 1'b1;
        end
    end

    task automatic check(input string name, input int got, input int expv);
        n_cmp = n_cmp + 1;
        if (got != expv) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Toggle io after p negedges and queue the events it must produce
    task automatic half(input int p, input int qoff, input bit timed);
        exp_t e;
        repeat (p) @(negedge clk);
        io_clk_i = ~io_clk_i;
        e.kind = io_clk_i ? K_RISE : K_FALL;
        e.cyc  = timed ? cyc + 3 : -1;
        sb.push_back(e);
        if (qoff > 0) begin
            e.kind = io_clk_i ? K_HQ : K_LQ;
            e.cyc  = timed ? cyc + 3 + qoff : -1;
            sb.push_back(e);
        end
    endtask

    initial begin
        logic [3:0] last;
        logic [3:0] now;
        exp_t       e;
        last = 4'b0;
        forever begin
            @(negedge clk);
            now = {rec_if.recovered_state_o.events.low_quarter,
                   rec_if.recovered_state_o.events.high_quarter,
                   rec_if.recovered_state_o.events.falling,
                   rec_if.recovered_state_o.events.rising};
            for (int k = 0; k < 4; k++) begin
                if (now[k] && !last[k]) begin
                    check("event_after_enabled_edge", int'(en_at_edge), 1);
                    if (sb.size() == 0) begin
                        n_cmp = n_cmp + 1;
                        n_err = n_err + 1;
                        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", k, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind", k, e.kind);
                        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
                    end
                end
            end
            last = rst_n ? now : 4'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with io toggling
        repeat (4) begin
            repeat (3) @(negedge clk);
            io_clk_i = ~io_clk_i;
        end
        @(negedge clk);
        check("reset_state", int'(rec_if.recovered_state_o), 0);
        check("reset_half_rate", int'(rec_if.half_rate_o), 0);
        rst_n = 1'b1;

        // Enable low: io activity produces nothing
        repeat (4) begin
            repeat (3) @(negedge clk);
            io_clk_i = ~io_clk_i;
        end
        repeat (6) @(negedge clk);
        check("idle_state", int'(rec_if.recovered_state_o), 0);
        check("idle_half_rate", int'(rec_if.half_rate_o), 0);

        // Lock at half period 5
        enable_i = 1'b1;
        repeat (5) half(5, 0, 1'b1);
        half(5, 2, 1'b1);
        repeat (2) @(negedge clk);
        check("lock_not_yet", int'(rec_if.recovered_state_o.status.locked), 0);
        @(negedge clk);
        check("lock_asserted", int'(rec_if.recovered_state_o.status.locked), 1);
        check("lock_half_rate", int'(rec_if.half_rate_o), 5);

        // Jitter within tolerance keeps lock
        half(2, 2, 1'b1);
        half(4, 2, 1'b1);
        half(6, 2, 1'b1);
        half(5, 2, 1'b1);
        repeat (3) @(negedge clk);
        check("jitter_locked", int'(rec_if.recovered_state_o.status.locked), 1);
        check("jitter_half_rate", int'(rec_if.half_rate_o), 5);

        // Half period 8 breaks lock, then relocks at 8
        half(5, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("unlock_locked", int'(rec_if.recovered_state_o.status.locked), 0);
        check("unlock_half_rate", int'(rec_if.half_rate_o), 0);
        half(5, 0, 1'b1);
        half(8, 0, 1'b1);
        half(8, 0, 1'b1);
        half(8, 4, 1'b1);
        repeat (3) @(negedge clk);
        check("relock8_locked", int'(rec_if.recovered_state_o.status.locked), 1);
        check("relock8_half_rate", int'(rec_if.half_rate_o), 8);

        // Back to 5, then stop the io clock
        half(2, 0, 1'b1);
        repeat (3) half(5, 0, 1'b1);
        half(5, 2, 1'b1);
        repeat (15) @(negedge clk);
        check("stop_before_timeout", int'(rec_if.recovered_state_o.status.locked), 1);
        @(negedge clk);
        check("stop_timeout_locked", int'(rec_if.recovered_state_o.status.locked), 0);
        check("stop_timeout_half_rate", int'(rec_if.half_rate_o), 0);
        repeat (10) @(negedge clk);

        // From FIRST: the next edge still fires, and six edges relock
        half(10, 0, 1'b1);
        repeat (4) half(5, 0, 1'b1);
        half(5, 2, 1'b1);
        repeat (3) @(negedge clk);
        check("relock5_locked", int'(rec_if.recovered_state_o.status.locked), 1);

        // clear_state_i on the edge-detect cycle suppresses the event
        repeat (2) @(negedge clk);
        io_clk_i = ~io_clk_i;
        repeat (2) @(negedge clk);
        clear_state_i = 1'b1;
        @(negedge clk);
        clear_state_i = 1'b0;
        check("clear_locked", int'(rec_if.recovered_state_o.status.locked), 0);
        check("clear_half_rate", int'(rec_if.half_rate_o), 0);

        // clk_en at 50%, io half period 10 enabled cycles
        en_toggle = 1'b1;
        repeat (5) half(20, 0, 1'b0);
        half(20, 5, 1'b0);
        repeat (20) @(negedge clk);
        check("clken_locked", int'(rec_if.recovered_state_o.status.locked), 1);
        check("clken_half_rate", int'(rec_if.half_rate_o), 10);
        half(0, 5, 1'b0);
        repeat (24) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", int'(rec_if.recovered_state_o), 0);
        check("async_reset_half_rate", int'(rec_if.half_rate_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_recovery.md
# clock_recovery

Receive-side counterpart of the clks_alot clock generator. Samples an external, asynchronous io clock, measures its half period in system-clock cycles, and locks once the period is stable. Emits the same `clks_alot_p::clock_states_s` bundle the generator produces (level, edge/quarter events, lock status), so downstream logic consumes generated and recovered clocks identically. Sits at the input pins of any clks_alot peripheral that receives a forwarded clock.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth, min 2.
- `LOCK_COUNT`, default 4: consecutive in-tolerance half periods required to lock, min 1.
- `TOLERANCE`, default 1: max absolute deviation, in cycles, between a measured half period and the reference.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `clk_en` input 1: qualifies every state update except the synchronizer.
- `enable_i` input 1: recovery active; low forces IDLE.
- `clear_state_i` input 1: synchronous clear to IDLE, qualified by clk_en.
- `io_clk_i` input 1: asynchronous external clock.
- `recovered_state_o` output `clks_alot_p::clock_states_s`: clk, events, status.
- `half_rate_o` output `clks_alot_p::RATE_COUNTER_WIDTH`: locked half period in cycles, 0 when unlocked.

## Operation
- Synchronizer: `SYNC_STAGES` flops, clocked every `clk`, ungated. A delay flop `prev` (clk_en-gated) holds the last synchronized level. Edge = sync output != `prev`.
- Phase counter, RATE_COUNTER_WIDTH bits:
  - cleared to 0 on an edge, else +1 per clk_en cycle, saturating at all-ones.
  - At an edge, sample = phase + 1, saturating.
- FSM states:
  - IDLE -> FIRST when enable_i is high.
  - FIRST: first edge is discarded (partial period), clears phase, -> ACQUIRE with reference = 0, match = 0.
  - ACQUIRE, per edge: if |sample - reference| <= TOLERANCE then match++, else reference = sample and match = 0. When match reaches LOCK_COUNT -> LOCKED.
  - LOCKED, per edge: mismatch -> ACQUIRE with reference = sample and match = 0.
  - LOCKED timeout: phase > 2*reference + TOLERANCE, or phase saturated -> FIRST (clock stopped).
  - Priority: clear_state_i, then enable_i low -> IDLE; else normal transitions.
- Outputs:
  - clk = `prev`.
  - events.rising and events.falling: one-cycle pulses on each detected edge, in every state except IDLE.
  - Quarter events, LOCKED only: pulse when phase == reference>>1 and reference>>1 >= 1; high-phase if clk = 1, low-phase if clk = 0.
  - status.locked = (state == LOCKED).
  - half_rate_o = reference in LOCKED, else 0.
  - status.pause_active = 0, status.pause_duration = 0.
- Reset: state IDLE; synchronizer, prev, phase, reference, match, all events, locked and half_rate_o all 0.

## Timing
- All registered outputs update on the clk_en cycle of the edge that caused them.
- Latency from io_clk_i transition to event pulse: SYNC_STAGES+1 clk edges when clk_en is continuously high.
- clk_en low: the FSM, counters and prev freeze. The synchronizer keeps running, so a pending edge is detected on the next clk_en cycle. An even number of io edges during a stall is lost, which is acceptable.
- Lock asserts in the cycle after the LOCK_COUNT-th matching edge, together with half_rate_o.
- Unlock on mismatch or timeout drops locked and half_rate_o in the same registered update as the state change.
- Edge coincident with clear_state_i: the clear wins and no event fires.
- rst_n asserted mid-operation: all outputs go to 0 immediately (asynchronous). Release is synchronous to clk through the team reset synchronizer.

## Structure
- `clks_alot_p` already provides `clock_states_s` and `RATE_COUNTER_WIDTH`. Add there:
  - `recovery_state_e` with values IDLE, FIRST, ACQUIRE, LOCKED.
  - `RECOVERY_SYNC_STAGES_DEFAULT`.
- Sub-module `io_sync`: a parameterized N-stage synchronizer, reusable elsewhere.
- Event pulses are produced locally. The generator's event_generation block is not reused, because edges here are observed rather than scheduled.

## Test plan
All directed tests use SYNC_STAGES=2, LOCK_COUNT=4, TOLERANCE=1, clk_en high unless stated.
- Reset: hold rst_n low with io_clk_i toggling -> every output 0; after release, state stays IDLE while enable_i is low.
- Lock: half period 5 -> locked=1 the cycle after the 6th edge; half_rate_o=5; rising/falling pulse 3 clks after each io transition; quarter pulse 2 clks after each edge event.
- Jitter: locked at 5, then half periods 4,6,5 -> stays locked. Then a half period of 8 -> locked=0, half_rate_o=0; relock after 4 more 8-cycle half periods with half_rate_o=8.
- Stop: locked at 5, then io held -> timeout when phase reaches 12; state FIRST, locked=0, no events.
- clear_state_i coincident with an edge -> no event; state IDLE next cycle.
- clk_en 50% duty, io half period 10 clk_en cycles -> locks with half_rate_o=10; no event fires during a clk_en-low cycle.
